// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, reset PC, queue entry type and FSM encoding
//                for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // Explicit state encodings, kept as plain constants for legacy users
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN
    } fetch_state_e;

    // One queued instruction: the word and the PC it was fetched from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; wraps naturally at 2^ADDR_W
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Small circular FIFO of fetch_entry_t with flush. Wrapping
//                read/write pointers plus an explicit occupancy count.
//                Push and pop may happen together, even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    fetch_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_do_pop;
    logic w_do_push;

    assign full_o  = (count_q == CNT_W'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full queue may accept a push
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Entry storage; cleared on reset so the head reads zero when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Pointers and occupancy; a flush overrides any push/pop in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Generates the PC, drives the
//                one-cycle-latency cache read port, captures returned words
//                into fetch_queue and presents them to decode over a
//                valid/ready handshake. Handles branch redirects, discarding
//                queued and in-flight fetches.
//                Optional macro FETCH_PERF_EN adds saturating bubble and
//                redirect counters (perf_bubble_cnt, perf_redirect_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_r_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_bubble_cnt,
    output logic [15:0]       perf_redirect_cnt
`endif
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e      state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q,  inflight_d;
    logic              kill_q,      kill_d;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_credit;
    logic [OCC_W-1:0]  w_occ;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    assign inst_valid = !w_empty;
    assign inst_data  = w_head.instr;
    assign inst_pc    = w_head.pc;
    assign w_pop      = inst_valid && inst_ready;

    // Occupancy counts the slot freed by a same-cycle pop so that a stream
    // with decode always ready sustains one fetch per cycle.
    assign w_occ    = {1'b0, w_count} + OCC_W'(inflight_q) - OCC_W'(w_pop);
    assign w_credit = (w_occ < OCC_W'(QDEPTH));
    assign w_issue  = (state_q == RUN) && !redirect_valid && w_credit;

    assign imem_r_en = w_issue;
    assign imem_addr = pc_q;

    // Returned word is queued unless its read was cancelled by a redirect
    assign w_push       = inflight_q && !kill_q && (!w_full || w_pop);
    assign w_push_entry = '{pc: issued_pc_q, instr: imem_data};

    fetch_queue #(
        .QDEPTH       (QDEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_valid),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_count),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    // Next-state: BOOT lasts one cycle; a redirect always reloads the PC
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = w_issue;
        kill_d      = redirect_valid;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (w_issue) begin
            pc_d        = pc_incr(pc_q);
            issued_pc_d = pc_q;
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            kill_q      <= kill_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_bubble_q;
    logic [15:0] perf_redirect_q;
    logic        w_bubble;

    assign w_bubble          = (state_q == RUN) && !inst_valid && !redirect_valid;
    assign perf_bubble_cnt   = perf_bubble_q;
    assign perf_redirect_cnt = perf_redirect_q;

    // Saturating counters of empty-output cycles and redirect strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bubble_q   <= 16'h0000;
            perf_redirect_q <= 16'h0000;
        end else begin
            if (w_bubble && (perf_bubble_q != 16'hFFFF)) begin
                perf_bubble_q <= perf_bubble_q + 16'd1;
            end
            if (redirect_valid && (perf_redirect_q != 16'hFFFF)) begin
                perf_redirect_q <= perf_redirect_q + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Cache model returns
//                mem[a] = a one cycle after a read. A scoreboard of expected
//                (pc, data) pairs is loaded on reset and on each redirect and
//                drained as decode accepts instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [15:0] TB_RESET_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        imem_r_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_bubble_cnt;
    logic [15:0] perf_redirect_cnt;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   seg_pops;
    int   n_checks;
    int   n_fail;
    logic [15:0] mem_rd_q;

    fetch_unit #(.QDEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_r_en         (imem_r_en),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst_data         (inst_data),
        .inst_pc           (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: word at address a is a, returned the cycle after the read
    always @(posedge clk) begin
        if (imem_r_en) mem_rd_q <= imem_addr;
    end
    assign imem_data = mem_rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push_stream(input logic [15:0] start, input int n);
        logic [15:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{pc: p, data: p});
            p = p + 16'd1;
        end
    endtask

    // Scoreboard: reload on reset/redirect, compare every accepted instruction
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb_q.delete();
            sb_push_stream(TB_RESET_PC, 32);
            seg_pops = 0;
        end else begin
            if (inst_valid && inst_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underrun", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", 32'(inst_pc), 32'(e.pc));
                    check("sb_data", 32'(inst_data), 32'(e.data));
                    seg_pops++;
                end
            end
            if (redirect_valid) begin
                sb_q.delete();
                sb_push_stream(redirect_pc, 32);
                seg_pops = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max && !ok) begin
            tick();
            cyc++;
            if (inst_valid) ok = 1'b1;
        end
    endtask

    task automatic do_redirect(input logic [15:0] target, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        inst_ready     = rdy;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic stall_cycles(input int n);
        inst_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("stall_valid", 32'(inst_valid), 32'd1);
            if (sb_q.size() > 0) check("stall_hold_pc", 32'(inst_pc), 32'(sb_q[0].pc));
        end
        check("stall_full_r_en", 32'(imem_r_en), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ok;
        bit found;
        n_checks       = 0;
        n_fail         = 0;
        seg_pops       = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        inst_ready     = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_r_en",  32'(imem_r_en),  32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data",  32'(inst_data),  32'd0);
        check("rst_pc",    32'(inst_pc),    32'd0);
        check("rst_addr",  32'(imem_addr),  32'(TB_RESET_PC));

        // Release: one BOOT cycle with no issue, first valid at edge 3
        reset = 1'b0;
        #1;
        check("boot_no_issue", 32'(imem_r_en), 32'd0);
        wait_valid(10, cyc, ok);
        check("first_valid_ok", 32'(ok), 32'd1);
        check("first_valid_cycle", 32'(cyc), 32'd3);
        check("first_pc", 32'(inst_pc), 32'(TB_RESET_PC));
`ifdef FETCH_PERF_EN
        check("perf_bubble_boot", 32'(perf_bubble_cnt), 32'd2);
        check("perf_redir_boot", 32'(perf_redirect_cnt), 32'd0);
`endif

        // Gapless stream until the read of pc=5 is issued
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_r_en && imem_addr == 16'd5) begin
                found = 1'b1;
            end else begin
                tick();
                check("stream_gapless", 32'(inst_valid), 32'd1);
            end
        end
        check("found_pc5_issue", 32'(found), 32'd1);

        // Redirect while pc=5 is in flight
        tick();
        do_redirect(16'h0040, 1'b1);
        check("redir_flush_valid", 32'(inst_valid), 32'd0);
        wait_valid(10, cyc, ok);
        check("redir_latency", 32'(cyc), 32'd2);
        check("redir_pc", 32'(inst_pc), 32'h0040);
        check("redir_data", 32'(inst_data), 32'h0040);
        repeat (6) tick();

        // Redirect near the top of the address space: wraps to 0
        do_redirect(16'hFFFE, 1'b1);
        repeat (8) tick();
        check("wrap_pops", 32'(seg_pops >= 4), 32'd1);

        // Fill the queue, then redirect with a same-cycle pop
        stall_cycles(5);
        do_redirect(16'h1234, 1'b1);
        check("full_redir_gap1", 32'(inst_valid), 32'd0);
        tick();
        check("full_redir_gap2", 32'(inst_valid), 32'd0);
        tick();
        check("full_redir_valid", 32'(inst_valid), 32'd1);
        check("full_redir_pc", 32'(inst_pc), 32'h1234);
        repeat (3) tick();

        // Asynchronous reset with the queue full
        stall_cycles(5);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_r_en",  32'(imem_r_en),  32'd0);
        check("async_rst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_pc",    32'(inst_pc),    32'd0);
        check("async_rst_addr",  32'(imem_addr),  32'(TB_RESET_PC));
`ifdef FETCH_PERF_EN
        check("async_rst_bubble", 32'(perf_bubble_cnt), 32'd0);
        check("async_rst_redir",  32'(perf_redirect_cnt), 32'd0);
`endif
        tick();
        reset = 1'b0;
        wait_valid(10, cyc, ok);
        check("restart_latency", 32'(cyc), 32'd3);
        check("restart_pc", 32'(inst_pc), 32'(TB_RESET_PC));

        // Decode stalls after the first valid, then drains with no gaps
        stall_cycles(5);
        check("stall_pc_zero", 32'(inst_pc), 32'(TB_RESET_PC));
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("release_gapless", 32'(inst_valid), 32'd1);
        end
        check("release_pops", 32'(seg_pops >= 9), 32'd1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
